cmem_fill: RTL and testbench
============================

CMEM_FILL -- requirements
Module: cmem_fill

Interface
REQ-001 Parameter: CMEM_LINE, default `CMEM_LINE (256), line width in bits; SHALL be a multiple of BEAT_W.
REQ-002 Parameter: CMEM_BLK_LEN, default `CMEM_BLK_LEN (59), line block address width.
REQ-003 Parameter: BEAT_W, default 64, memory beat width; BEATS = CMEM_LINE/BEAT_W (default 4).
REQ-004 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Port: rst  in  1  asynchronous, active-high reset.
REQ-006 Port: b_addr_c  in  CMEM_BLK_LEN  line block address from cache.
REQ-007 Port: b_rd_c  in  1  line fill request level from cache.
REQ-008 Port: b_rdata_c  out  CMEM_LINE  assembled line.
REQ-009 Port: b_dv_c  out  1  line valid strobe, one cycle.
REQ-010 Port: m_addr  out  64  byte address of burst; low log2(CMEM_LINE/8) bits zero.
REQ-011 Port: m_req  out  1  burst request; held until m_gnt.
REQ-012 Port: m_gnt  in  1  burst accepted when m_req && m_gnt.
REQ-013 Port: m_rdata  in  BEAT_W  beat data, beat 0 first (ascending address).
REQ-014 Port: m_rvalid  in  1  beat valid; no backpressure.
REQ-015 Port: m_rerr  in  1  beat error, qualified by m_rvalid.
REQ-016 Port: fill_err  out  1  sticky error flag, cleared by next accepted request.
REQ-017 Port: fill_cnt  out  32  completed fills counter, wraps 0xFFFFFFFF->0.

Function
REQ-018 FSM states SHALL be IDLE, REQ, BEAT, DONE, DRAIN.
REQ-019 IDLE: on b_rd_c=1 latch b_addr_c, clear beat counter and fill_err, go REQ.
REQ-020 REQ: m_req=1, m_addr={latched addr, zeros}; on m_gnt go BEAT; m_addr SHALL be stable while m_req.
REQ-021 BEAT: each m_rvalid writes m_rdata to b_rdata_c[BEAT_W*cnt +: BEAT_W], cnt+1; m_rvalid outside BEAT/DRAIN SHALL be ignored.
REQ-022 On beat BEATS-1 accepted, go DONE; b_dv_c=1 in exactly the DONE cycle, then IDLE.
REQ-023 b_rdata_c SHALL hold the last assembled line until the next fill's beat 0 is written.
REQ-024 m_rerr on any beat SHALL set fill_err; fill still completes and b_dv_c still pulses.
REQ-025 If b_rd_c drops while in REQ, request SHALL still be held until m_gnt (no withdrawal), then DRAIN.
REQ-026 If b_rd_c drops in BEAT, go DRAIN; DRAIN consumes remaining beats without b_dv_c, then IDLE.
REQ-027 fill_cnt SHALL increment once per DONE cycle only.
REQ-028 Minimum latency: b_rd_c sampled cycle 0, m_req cycle 1, zero-wait gnt and back-to-back beats cycles 2..5, b_dv_c cycle 6.
REQ-029 A request asserted in the DONE cycle SHALL NOT be accepted before IDLE (no re-trigger on stale b_rd_c).

Reset
REQ-030 rst SHALL asynchronously force IDLE; m_req=0, b_dv_c=0, fill_err=0, fill_cnt=0, beat counter=0, b_rdata_c=0, m_addr=0.
REQ-031 Reset mid-burst SHALL abandon the burst; beats arriving after reset release in IDLE SHALL be ignored.

Structure
REQ-032 CMEM_LINE, CMEM_BLK_LEN, beat width and FSM state encodings SHALL live in shared config.vh.
REQ-033 Single module; no sub-module required.

Verification
REQ-034 Fill addr 0x10, gnt immediate, beats 0x0,0x1,0x2,0x3 -> b_dv_c cycle 6, b_rdata_c={3,2,1,0}, m_addr=0x200, fill_cnt=1.
REQ-035 gnt delayed 5 cycles, beats gapped by 2 idle cycles -> m_addr stable, single b_dv_c after beat 3, data correct.
REQ-036 m_rerr on beat 2 -> b_dv_c pulses, fill_err=1; next request clears fill_err.
REQ-037 b_rd_c dropped after beat 1 -> remaining 2 beats drained, no b_dv_c, fill_cnt unchanged, next fill correct.
REQ-038 rst asserted during beat 2 -> outputs reset immediately; stray beats ignored; following fill completes normally.
REQ-039 fill_cnt preset via 0xFFFFFFFF fills (forced) -> one more fill wraps to 0.

Source files
------------

// File: rtl/cmem_fill_pkg.sv
// rtl/cmem_fill_pkg.sv - shared configuration for the cache line fill engine
// Holds the default line geometry, the memory address width and the
// fill FSM state encoding used by cmem_fill.
package cmem_fill_pkg;

  localparam int CMEM_LINE_DEF    = 256;  // line width in bits
  localparam int CMEM_BLK_LEN_DEF = 59;   // line block address width
  localparam int BEAT_W_DEF       = 64;   // memory beat width in bits
  localparam int MEM_ADDR_W       = 64;   // byte address width on the memory side

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_BEAT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } fill_state_t;

endpackage

// File: rtl/cmem_fill.sv
// rtl/cmem_fill.sv - cache line fill engine assembling a line from memory beats
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   b_addr_c, b_rd_c    line block address and fill request level from cache
//   b_rdata_c, b_dv_c   assembled line and its one-cycle valid strobe
//   m_addr, m_req/m_gnt burst byte address and request handshake
//   m_rdata, m_rvalid,  beat data (beat 0 first), beat valid, beat error
//   m_rerr
//   fill_err            sticky error, cleared when the next request is accepted
//   fill_cnt            number of completed fills (wrapping)
module cmem_fill
  import cmem_fill_pkg::*;
#(
  parameter int CMEM_LINE    = CMEM_LINE_DEF,
  parameter int CMEM_BLK_LEN = CMEM_BLK_LEN_DEF,
  parameter int BEAT_W       = BEAT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CMEM_BLK_LEN-1:0] b_addr_c,
  input  logic                    b_rd_c,
  output logic [CMEM_LINE-1:0]    b_rdata_c,
  output logic                    b_dv_c,
  output logic [MEM_ADDR_W-1:0]   m_addr,
  output logic                    m_req,
  input  logic                    m_gnt,
  input  logic [BEAT_W-1:0]       m_rdata,
  input  logic                    m_rvalid,
  input  logic                    m_rerr,
  output logic                    fill_err,
  output logic [31:0]             fill_cnt
);

  localparam int BEATS  = CMEM_LINE / BEAT_W;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W  = $clog2(CMEM_LINE / 8);
  localparam int FULL_W = CMEM_BLK_LEN + OFF_W;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  fill_state_t               state_q, state_d;
  logic [CMEM_BLK_LEN-1:0]   addr_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [CMEM_LINE-1:0]      line_q;
  logic                      err_q;
  logic                      drop_q;   // cache withdrew its request while we waited for grant
  logic [31:0]               fill_cnt_q;
  logic                      beat_en;
  logic [FULL_W-1:0]         addr_full;

  assign addr_full = {addr_q, {OFF_W{1'b0}}};
  assign m_addr    = MEM_ADDR_W'(addr_full);
  assign b_rdata_c = line_q;
  assign fill_err  = err_q;
  assign fill_cnt  = fill_cnt_q;

  // Beats are only meaningful once the burst has been granted.
  assign beat_en = m_rvalid && ((state_q == S_BEAT) || (state_q == S_DRAIN));

  always_comb begin
    state_d = state_q;
    m_req   = 1'b0;
    b_dv_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (b_rd_c) state_d = S_REQ;
      end
      S_REQ: begin
        // The request is never withdrawn; a dropped fill is drained after grant.
        m_req = 1'b1;
        if (m_gnt) state_d = (drop_q || !b_rd_c) ? S_DRAIN : S_BEAT;
      end
      S_BEAT: begin
        if (m_rvalid && (cnt_q == LAST_BEAT)) state_d = b_rd_c ? S_DONE : S_IDLE;
        else if (!b_rd_c)                     state_d = S_DRAIN;
      end
      S_DONE: begin
        b_dv_c  = 1'b1;
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (m_rvalid && (cnt_q == LAST_BEAT)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      line_q     <= '0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
      fill_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && b_rd_c) begin
        addr_q <= b_addr_c;
        cnt_q  <= '0;
        err_q  <= 1'b0;
        drop_q <= 1'b0;
      end
      if ((state_q == S_REQ) && !b_rd_c) drop_q <= 1'b1;
      if (beat_en) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (m_rerr) err_q <= 1'b1;
        // Drained beats are discarded so the previous line stays visible.
        if (state_q == S_BEAT) line_q[BEAT_W*cnt_q +: BEAT_W] <= m_rdata;
      end
      if (state_q == S_DONE) fill_cnt_q <= fill_cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_cmem_fill.sv
// tb/tb_cmem_fill.sv - scoreboard bench for the cache line fill engine
module tb_cmem_fill;

  typedef struct packed {
    logic [255:0] line;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [58:0]  b_addr_c;
  logic         b_rd_c;
  logic [255:0] b_rdata_c;
  logic         b_dv_c;
  logic [63:0]  m_addr;
  logic         m_req;
  logic         m_gnt;
  logic [63:0]  m_rdata;
  logic         m_rvalid;
  logic         m_rerr;
  logic         fill_err;
  logic [31:0]  fill_cnt;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           t0 = 0;
  int           last_dv_cyc = -1;
  logic [31:0]  exp_cnt = 0;

  cmem_fill dut (
    .clk(clk), .rst(rst),
    .b_addr_c(b_addr_c), .b_rd_c(b_rd_c),
    .b_rdata_c(b_rdata_c), .b_dv_c(b_dv_c),
    .m_addr(m_addr), .m_req(m_req), .m_gnt(m_gnt),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rerr(m_rerr),
    .fill_err(fill_err), .fill_cnt(fill_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every line strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && b_dv_c) begin
      last_dv_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_dv: got b_dv_c=1 expected no strobe at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("line_data", b_rdata_c, e.line);
        check("line_err", 256'(fill_err), 256'(e.err));
      end
    end
  end

  task automatic start_req(input logic [58:0] a);
    bit ok;
    b_rd_c   = 1'b1;
    b_addr_c = a;
    t0       = cyc;
    ok       = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (m_req) begin ok = 1'b1; break; end
    end
    check("m_req_seen", 256'(ok), 256'(1'b1));
    check("m_addr", 256'(m_addr), 256'({a, 5'b0}));
    check("err_clear", 256'(fill_err), 256'(1'b0));
  endtask

  task automatic grant(input int gdly, input logic [58:0] a);
    for (int i = 0; i < gdly; i++) begin
      @(posedge clk); #1;
      check("m_addr_stable", 256'({m_req, m_addr}), 256'({1'b1, a, 5'b0}));
    end
    m_gnt = 1'b1;
    @(posedge clk); #1;
    m_gnt = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic e);
    m_rvalid = 1'b1;
    m_rdata  = d;
    m_rerr   = e;
    @(posedge clk); #1;
    m_rvalid = 1'b0;
    m_rerr   = 1'b0;
  endtask

  task automatic fill(input logic [58:0] a, input int gdly, input int gap, input int errb,
                      input logic [63:0] base, input logic [255:0] exp_line);
    exp_t e;
    e.line = exp_line;
    e.err  = (errb >= 0);
    exp_q.push_back(e);
    start_req(a);
    grant(gdly, a);
    for (int i = 0; i < 4; i++) begin
      repeat (gap) begin @(posedge clk); #1; end
      send_beat(base + 64'(i), i == errb);
    end
    b_rd_c = 1'b0;   // now in the strobe cycle; drop the level
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 32'd1;
    check("fill_cnt", 256'(fill_cnt), 256'(exp_cnt));
  endtask

  initial begin
    rst = 1'b1; b_addr_c = '0; b_rd_c = 1'b0; m_gnt = 1'b0;
    m_rdata = '0; m_rvalid = 1'b0; m_rerr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", 256'({m_req, b_dv_c, fill_err, fill_cnt, m_addr}), 256'(0));
    check("rst_rdata", b_rdata_c, 256'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic zero-wait fill.
    fill(59'h10, 0, 0, -1, 64'h0,
         {64'h3, 64'h2, 64'h1, 64'h0});
    check("latency", 256'(last_dv_cyc), 256'(t0 + 6));
    repeat (3) begin @(posedge clk); #1; end
    check("line_hold", b_rdata_c, {64'h3, 64'h2, 64'h1, 64'h0});

    // Delayed grant, gapped beats.
    fill(59'h1234, 5, 2, -1, 64'hA5A5_0000_0000_0010,
         {64'hA5A5_0000_0000_0013, 64'hA5A5_0000_0000_0012,
          64'hA5A5_0000_0000_0011, 64'hA5A5_0000_0000_0010});

    // Error on beat 2: still strobes, flag set, cleared by next request.
    fill(59'h7, 1, 0, 2, 64'hDEAD_BEEF_0000_0000,
         {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002,
          64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000});
    check("err_sticky", 256'(fill_err), 256'(1'b1));

    // Request dropped after beat 1: remaining beats drained, no strobe.
    start_req(59'h55);
    grant(0, 59'h55);
    send_beat(64'h100, 1'b0);
    send_beat(64'h101, 1'b0);
    b_rd_c = 1'b0;
    @(posedge clk); #1;
    send_beat(64'h102, 1'b0);
    send_beat(64'h103, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    check("drop_cnt", 256'(fill_cnt), 256'(exp_cnt));
    fill(59'h56, 0, 0, -1, 64'h200,
         {64'h203, 64'h202, 64'h201, 64'h200});

    // Request dropped while waiting for grant: request held, then drained.
    start_req(59'h60);
    b_rd_c = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("req_held", 256'({m_req, m_addr}), 256'({1'b1, 59'h60, 5'b0}));
    grant(0, 59'h60);
    for (int i = 0; i < 4; i++) send_beat(64'h300 + 64'(i), 1'b0);
    @(posedge clk); #1;
    check("req_drop_cnt", 256'(fill_cnt), 256'(exp_cnt));

    // Reset during beat 2, then stray beats, then a normal fill.
    start_req(59'h33);
    grant(0, 59'h33);
    send_beat(64'h400, 1'b0);
    send_beat(64'h401, 1'b0);
    m_rvalid = 1'b1; m_rdata = 64'h402;
    #2 rst = 1'b1;
    #1;
    check("midrst_outputs", 256'({m_req, b_dv_c, fill_err, fill_cnt, m_addr}), 256'(0));
    check("midrst_rdata", b_rdata_c, 256'(0));
    m_rvalid = 1'b0;
    b_rd_c   = 1'b0;
    exp_cnt  = 32'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    send_beat(64'h402, 1'b1);
    send_beat(64'h403, 1'b0);
    check("stray_ignored", 256'({b_rdata_c, fill_err}), 256'(0));
    fill(59'h34, 0, 1, -1, 64'h500,
         {64'h503, 64'h502, 64'h501, 64'h500});

    // Counter wrap from a preset all-ones value.
    force dut.fill_cnt_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.fill_cnt_q;
    @(posedge clk); #1;
    check("cnt_preset", 256'(fill_cnt), 256'(32'hFFFF_FFFF));
    exp_cnt = 32'hFFFF_FFFF;
    fill(59'h1, 0, 0, -1, 64'h600,
         {64'h603, 64'h602, 64'h601, 64'h600});

    repeat (4) begin @(posedge clk); #1; end
    check("all_lines_seen", 256'(exp_q.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
